// File: rtl/ts_tracklet_mux_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ts_tracklet_mux_fifo_pkg
// Shared constants and helpers for the tracklet merge FIFO slice.
//
// STRUCT_TRACKLET_DATA_BITS mirrors the packed tracklet word width kept in
// the shared Constants.txt. The tracklet field boundaries also live there.
// This block moves the word as an opaque vector, so no field positions are
// declared in this package.
// ---------------------------------------------------------------------------
package ts_tracklet_mux_fifo_pkg;

  localparam int STRUCT_TRACKLET_DATA_BITS = 64;

  // Width of a channel index. It never drops below one bit, so that a
  // single-channel build still has a legal out_ch port.
  function automatic int chIdxBits(input int nCh);
    return (nCh > 1) ? $clog2(nCh) : 1;
  endfunction

endpackage

// File: rtl/ts_tracklet_fifo_ch.sv
// ---------------------------------------------------------------------------
// ts_tracklet_fifo_ch
// One synchronous FIFO channel of the tracklet merger. It holds a circular
// buffer, wrapping read and write pointers, an occupancy count, full and
// almost-full flags, and a saturating counter of dropped writes.
//
// Ports
//   clk      : processing clock, rising edge
//   reset    : synchronous active-high reset (highest precedence)
//   flush    : empties the channel and ignores a write in the same cycle
//   wr_en    : write strobe for din
//   din      : tracklet word to store
//   pop      : the arbiter has taken rd_data this cycle
//   rd_data  : word at the head of the buffer (valid when !empty)
//   empty    : occupancy == 0
//   full     : occupancy == DEPTH
//   afull    : occupancy >= DEPTH-2
//   ovf_cnt  : number of writes dropped because the channel was full
// ---------------------------------------------------------------------------
module ts_tracklet_fifo_ch
  import ts_tracklet_mux_fifo_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = STRUCT_TRACKLET_DATA_BITS,
  parameter int OVF_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 afull,
  output logic [OVF_BITS-1:0]  ovf_cnt
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_BITS-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_BITS-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [OVF_BITS-1:0]  ovf_q, ovf_d;
  logic                 popEn;
  logic                 wrAccept;
  logic                 wrDrop;

  // Status flags come straight from the occupancy count. The pointers alone
  // cannot tell full from empty, because both states have equal pointers.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign afull   = (count_q >= CNT_BITS'(DEPTH - 2));
  assign rd_data = mem_q[rdPtr_q];
  assign ovf_cnt = ovf_q;

  // A pop frees a slot in the same cycle. A full channel that is being
  // drained therefore still takes the incoming word, and nothing is counted
  // as dropped. A write that arrives during a flush is neither stored nor
  // counted as dropped.
  assign popEn    = pop && !empty && !flush;
  assign wrAccept = wr_en && !flush && (!full || popEn);
  assign wrDrop   = wr_en && !flush && full && !popEn;

  // Next-state logic for the pointers, the count and the overflow counter.
  // The pointers are exactly log2(DEPTH) bits wide, so the increment wraps
  // modulo DEPTH with no extra logic. A flush clears the buffer state but
  // keeps the overflow history.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAccept) begin
        wrPtr_d = wrPtr_q + PTR_BITS'(1);
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + PTR_BITS'(1);
      end
      case ({wrAccept, popEn})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
    if (wrDrop && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_BITS'(1);
    end
  end

  // Control state register. Reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array. It has no reset, so it can map onto RAM. Stale contents
  // are harmless, because only the count decides what is readable. A word
  // written while full-and-popping lands in the slot being read this cycle.
  // The reader still sees the old word, since the array updates only at
  // the clock edge.
  always_ff @(posedge clk) begin
    if (!reset && wrAccept) begin
      mem_q[wrPtr_q] <= din;
    end
  end

endmodule

// File: rtl/ts_tracklet_mux_fifo.sv
// ---------------------------------------------------------------------------
// ts_tracklet_mux_fifo
// Merges N_CH independent tracklet write channels into one stream. Each
// channel has its own FIFO (ts_tracklet_fifo_ch). A round-robin arbiter
// feeds a single registered output stage that uses a valid/ready handshake.
//
// Ports
//   clk       : processing clock, rising edge
//   reset     : synchronous active-high reset (wins over flush and traffic)
//   flush     : drops every buffered word and the output word; keeps the
//               overflow counters and the round-robin position
//   wr_en     : per-channel write strobes
//   din       : per-channel words, channel k at [k*DATA_BITS +: DATA_BITS]
//   out_ready : downstream takes the current output word
//   out_valid : dout/out_ch hold a word
//   dout      : merged tracklet word
//   out_ch    : source channel of dout
//   ch_full   : per-channel full flags
//   ch_afull  : per-channel occupancy >= DEPTH-2 flags
//   ovf_cnt   : per-channel saturating dropped-write counters
// ---------------------------------------------------------------------------
module ts_tracklet_mux_fifo
  import ts_tracklet_mux_fifo_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DEPTH     = 16,
  parameter int DATA_BITS = STRUCT_TRACKLET_DATA_BITS,
  parameter int OVF_BITS  = 8,
  localparam int CH_BITS  = chIdxBits(N_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [N_CH-1:0]           wr_en,
  input  logic [N_CH*DATA_BITS-1:0] din,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_BITS-1:0]      dout,
  output logic [CH_BITS-1:0]        out_ch,
  output logic [N_CH-1:0]           ch_full,
  output logic [N_CH-1:0]           ch_afull,
  output logic [N_CH*OVF_BITS-1:0]  ovf_cnt
);

  logic [DATA_BITS-1:0] chData [N_CH];
  logic [N_CH-1:0]      chEmpty;
  logic [N_CH-1:0]      chPop;

  logic                 outValid_q, outValid_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic [CH_BITS-1:0]   outCh_q, outCh_d;
  logic [CH_BITS-1:0]   rrPtr_q, rrPtr_d;

  logic                 grantValid;
  logic [CH_BITS-1:0]   grantCh;
  logic                 loadEn;
  int                   searchIdx;

  // One FIFO per write channel. Each channel sees only its own slice of din
  // and its own pop strobe.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ts_tracklet_fifo_ch #(
      .DEPTH     (DEPTH),
      .DATA_BITS (DATA_BITS),
      .OVF_BITS  (OVF_BITS)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .wr_en   (wr_en[k]),
      .din     (din[k*DATA_BITS +: DATA_BITS]),
      .pop     (chPop[k]),
      .rd_data (chData[k]),
      .empty   (chEmpty[k]),
      .full    (ch_full[k]),
      .afull   (ch_afull[k]),
      .ovf_cnt (ovf_cnt[k*OVF_BITS +: OVF_BITS])
    );
  end

  // Round-robin search: pick the first non-empty channel after the last
  // granted one, going up and wrapping around. The loop walks the offsets
  // from farthest to nearest, so the nearest non-empty channel is written
  // last and wins, and no early exit is needed. rrPtr resets to the last
  // channel, so the first search after reset begins at channel 0.
  always_comb begin
    grantValid = 1'b0;
    grantCh    = '0;
    searchIdx  = 0;
    for (int i = N_CH; i >= 1; i--) begin
      searchIdx = int'(rrPtr_q) + i;
      if (searchIdx >= N_CH) begin
        searchIdx = searchIdx - N_CH;
      end
      if (!chEmpty[searchIdx]) begin
        grantValid = 1'b1;
        grantCh    = CH_BITS'(searchIdx);
      end
    end
  end

  // The output stage loads whenever it is empty or its word is being taken.
  // The granted channel is popped on that same edge, so a steady stream
  // moves one word per cycle. No load happens during a flush.
  assign loadEn = !flush && grantValid && (!outValid_q || out_ready);

  // Pop strobe for the granted channel only.
  always_comb begin
    chPop = '0;
    if (loadEn) begin
      chPop[grantCh] = 1'b1;
    end
  end

  // Next state of the output stage and the arbiter pointer. A stalled word
  // keeps dout/out_ch untouched. out_valid drops only once the current word
  // is taken and nothing is left to load. A flush empties the stage but
  // leaves the round-robin position where it was.
  always_comb begin
    outValid_d = outValid_q;
    dout_d     = dout_q;
    outCh_d    = outCh_q;
    rrPtr_d    = rrPtr_q;
    if (flush) begin
      outValid_d = 1'b0;
    end else if (loadEn) begin
      outValid_d = 1'b1;
      dout_d     = chData[grantCh];
      outCh_d    = grantCh;
      rrPtr_d    = grantCh;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Output stage and arbiter registers. Reset clears every visible output,
  // so no word that was buffered before the reset can show up afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q <= 1'b0;
      dout_q     <= '0;
      outCh_q    <= '0;
      rrPtr_q    <= CH_BITS'(N_CH - 1);
    end else begin
      outValid_q <= outValid_d;
      dout_q     <= dout_d;
      outCh_q    <= outCh_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign out_valid = outValid_q;
  assign dout      = dout_q;
  assign out_ch    = outCh_q;

endmodule

// File: tb/tb_ts_tracklet_mux_fifo.sv
// ---------------------------------------------------------------------------
// tb_ts_tracklet_mux_fifo
// Self-checking bench for ts_tracklet_mux_fifo with N_CH=4, DEPTH=16,
// OVF_BITS=8. Every stimulus word that is meant to emerge is pushed into an
// expected-word queue. A negedge monitor compares each word accepted
// downstream against that queue. The stimulus process also checks flags,
// counters and cycle timing directly.
// ---------------------------------------------------------------------------
module tb_ts_tracklet_mux_fifo;

  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int OB  = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ch;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              flush;
  logic [NCH-1:0]    wr_en;
  logic [NCH*DW-1:0] din;
  logic              out_ready;
  logic              out_valid;
  logic [DW-1:0]     dout;
  logic [1:0]        out_ch;
  logic [NCH-1:0]    ch_full;
  logic [NCH-1:0]    ch_afull;
  logic [NCH*OB-1:0] ovf_cnt;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  ts_tracklet_mux_fifo #(
    .N_CH      (NCH),
    .DEPTH     (16),
    .DATA_BITS (DW),
    .OVF_BITS  (OB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .wr_en     (wr_en),
    .din       (din),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dout      (dout),
    .out_ch    (out_ch),
    .ch_full   (ch_full),
    .ch_afull  (ch_afull),
    .ovf_cnt   (ovf_cnt)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] wr, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic [DW-1:0] d3);
    wr_en = wr;
    din   = {d3, d2, d1, d0};
  endtask

  task automatic pushExp(input logic [DW-1:0] d, input logic [1:0] c);
    expQ.push_back('{data: d, ch: c});
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    reset     = 1'b1;
    out_ready = 1'b0;
    applyStimulus('0, '0, '0, '0, '0);
    tick();
    reset = 1'b0;
    expQ.delete();
  endtask

  // Scoreboard monitor: the word seen at the negedge is handed over on the
  // next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_word actual=%0h/ch%0d expected=none", dout, out_ch);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (dout !== e.data || out_ch !== e.ch) begin
          failures++;
          $display("[TB] FAIL stream_word actual=%0h/ch%0d expected=%0h/ch%0d",
                   dout, out_ch, e.data, e.ch);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    applyStimulus('0, '0, '0, '0, '0);
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_dout", dout, 0);
    checkOutput("rst_ch", out_ch, 0);
    checkOutput("rst_full", ch_full, 0);
    checkOutput("rst_afull", ch_afull, 0);
    checkOutput("rst_ovf", ovf_cnt, 0);
    reset = 1'b0;

    $display("[TB] single word latency on ch2");
    out_ready = 1'b1;
    applyStimulus(4'b0100, 0, 0, 64'hA5, 0);
    pushExp(64'hA5, 2'd2);
    tick();
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("lat_early", out_valid, 0);
    tick();
    checkOutput("lat_valid", out_valid, 1);
    checkOutput("lat_dout", dout, 64'hA5);
    checkOutput("lat_ch", out_ch, 2);
    tick();
    checkOutput("lat_clear", out_valid, 0);

    $display("[TB] round robin after reset");
    resetDut();
    out_ready = 1'b1;
    applyStimulus(4'b1111, 64'h10, 64'h11, 64'h12, 64'h13);
    for (int k = 0; k < 4; k++) pushExp(64'h10 + 64'(k), 2'(k));
    tick();
    applyStimulus('0, '0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("rr_valid%0d", k), out_valid, 1);
      checkOutput($sformatf("rr_ch%0d", k), out_ch, 64'(k));
    end
    tick();
    checkOutput("rr_clear", out_valid, 0);

    $display("[TB] overflow on ch1 with output stalled");
    out_ready = 1'b0;
    applyStimulus(4'b0001, 64'hF0, 0, 0, 0);
    pushExp(64'hF0, 2'd0);
    tick();
    applyStimulus('0, '0, '0, '0, '0);
    tick();
    checkOutput("hold_valid", out_valid, 1);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(4'b0010, 0, 64'h100 + 64'(i), 0, 0);
      if (i < 16) pushExp(64'h100 + 64'(i), 2'd1);
      tick();
      if (i == 12) checkOutput("afull_13", ch_afull[1], 0);
      if (i == 13) checkOutput("afull_14", ch_afull[1], 1);
      if (i == 14) checkOutput("full_15", ch_full[1], 0);
      if (i == 15) checkOutput("full_16", ch_full[1], 1);
      if (i == 14) checkOutput("hold_dout", dout, 64'hF0);
    end
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("ovf_full", ch_full, 4'b0010);
    checkOutput("ovf_cnt2", ovf_cnt, 32'h0000_0200);
    out_ready = 1'b1;
    repeat (20) tick();
    checkOutput("ovf_drained", out_valid, 0);
    checkOutput("ovf_queue", 64'(expQ.size()), 0);

    $display("[TB] full ch0 streaming with write and pop together");
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(4'b0001, 64'h200 + 64'(i), 0, 0, 0);
      pushExp(64'h200 + 64'(i), 2'd0);
      tick();
    end
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("stream_full", ch_full, 4'b0001);
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      applyStimulus(4'b0001, 64'h300 + 64'(j), 0, 0, 0);
      pushExp(64'h300 + 64'(j), 2'd0);
      tick();
      checkOutput($sformatf("stream_full%0d", j), ch_full[0], 1);
      checkOutput($sformatf("stream_valid%0d", j), out_valid, 1);
    end
    applyStimulus('0, '0, '0, '0, '0);
    repeat (20) tick();
    checkOutput("stream_queue", 64'(expQ.size()), 0);
    checkOutput("stream_ovf", ovf_cnt, 32'h0000_0200);

    $display("[TB] flush with five words buffered");
    out_ready = 1'b0;
    applyStimulus(4'b1100, 0, 0, 64'h400, 64'h500);
    tick();
    applyStimulus(4'b1100, 0, 0, 64'h401, 64'h501);
    tick();
    applyStimulus(4'b0100, 0, 0, 64'h402, 0);
    tick();
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("flush_pre_valid", out_valid, 1);
    flush = 1'b1;
    applyStimulus(4'b1000, 0, 0, 0, 64'h5FF);
    tick();
    flush = 1'b0;
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_full", ch_full, 0);
    checkOutput("flush_afull", ch_afull, 0);
    checkOutput("flush_ovf", ovf_cnt, 32'h0000_0200);
    out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("flush_empty", out_valid, 0);

    $display("[TB] overflow saturation on ch3, then reset mid-stream");
    out_ready = 1'b0;
    for (int i = 0; i < 317; i++) begin
      applyStimulus(4'b1000, 0, 0, 0, 64'h600 + 64'(i));
      if (i < 17) pushExp(64'h600 + 64'(i), 2'd3);
      tick();
      if (i == 270) checkOutput("sat_254", ovf_cnt[31:24], 254);
      if (i == 271) checkOutput("sat_255", ovf_cnt[31:24], 255);
    end
    applyStimulus('0, '0, '0, '0, '0);
    checkOutput("sat_final", ovf_cnt[31:24], 255);
    checkOutput("sat_others", ovf_cnt[23:0], 24'h00_0200);
    out_ready = 1'b1;
    repeat (3) tick();
    reset     = 1'b1;
    out_ready = 1'b0;
    applyStimulus(4'b0001, 64'h7, 0, 0, 0);
    tick();
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_dout", dout, 0);
    checkOutput("mid_rst_ch", out_ch, 0);
    checkOutput("mid_rst_full", ch_full, 0);
    checkOutput("mid_rst_afull", ch_afull, 0);
    checkOutput("mid_rst_ovf", ovf_cnt, 0);
    reset = 1'b0;
    applyStimulus('0, '0, '0, '0, '0);
    expQ.delete();
    out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("post_rst_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
